sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-port arbiter that shares the single 512x8 synchronous SRAM between the serial control loader (scan/program-load path) and the 8-bit CPU core. It sits between both requesters and the SRAM macro pins, producing the registered `CEN_after_mux`, `WEN_after_mux`, `A_after_mux` and `D_after_mux` signals and routing `Q_from_SRAM` back to the port that issued the read. Owners can lock the SRAM for back-to-back bursts.

## Interface
Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM word width
- MEMORY_ADDR_WIDTH, 9, SRAM address width

Ports (clock and reset first; one clock, `CLK`; reset `RST_N` is asynchronous and active-low):
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- C_REQ  in  1  control-loader access request
- C_LOCK  in  1  control-loader keeps ownership after the current access
- C_WE  in  1  1 = write, 0 = read
- C_ADDR  in  MEMORY_ADDR_WIDTH  control-loader address
- C_WDATA  in  MEMORY_DATA_WIDTH  control-loader write data
- C_GNT  out  1  access accepted at this rising edge
- C_RVALID  out  1  C_RDATA valid this cycle
- C_RDATA  out  MEMORY_DATA_WIDTH  read data to control loader
- P_REQ, P_LOCK, P_WE, P_ADDR, P_WDATA  in  as C_*  CPU port
- P_GNT, P_RVALID, P_RDATA  out  as C_*  CPU port
- CEN_after_mux  out  1  SRAM chip enable, active-low, registered
- WEN_after_mux  out  1  SRAM write enable, active-low, registered
- A_after_mux  out  MEMORY_ADDR_WIDTH  SRAM address, registered
- D_after_mux  out  MEMORY_DATA_WIDTH  SRAM write data, registered
- Q_from_SRAM  in  MEMORY_DATA_WIDTH  SRAM read data

## Operation
- FSM states: IDLE, OWN_C, OWN_P.
- IDLE: if exactly one REQ is high, grant it. If both are high, apply the priority rule (see Configuration). No REQ: stay in IDLE with CEN=1.
- xGNT is combinational, asserted in the cycle where xREQ is high and the port wins. The access is accepted at the next rising edge.
- On acceptance, register CEN=0, WEN=~xWE, A=xADDR, D=xWDATA.
- Next state after acceptance: OWN_x if xLOCK=1, else IDLE.
- OWN_x: only port x can be granted. The other port's GNT is forced to 0.
  - xREQ=1: access accepted, with the same LOCK rule.
  - xREQ=0 and xLOCK=1: hold ownership with CEN=1.
  - xLOCK=0: return to IDLE (arbitrate in the same cycle).
- One access per cycle. Full throughput is a new accepted access every cycle.
- A cycle with no accepted access drives CEN=1 and WEN=1; A and D hold their last values.
- Read return:
  - A 2-bit shift pipeline tags each read with its owner.
  - xRVALID pulses exactly one cycle for each accepted read.
  - xRDATA = Q_from_SRAM while xRVALID=1, otherwise 0.
  - Writes never produce RVALID.
- The requester must hold REQ, WE, ADDR and WDATA stable until GNT is sampled high.

## Timing
- Reset values: CEN=1, WEN=1, A=0, D=0, C_GNT=P_GNT=0, C_RVALID=P_RVALID=0, RDATA=0, state=IDLE, round-robin pointer = C (when compiled in).
- Read latency: accepted at edge N → SRAM pins valid after N → SRAM samples at N+1 → xRVALID high between N+1 and N+2.
- Write latency: the SRAM captures at edge N+1.
- GNT is forced to 0 while RST_N=0.
- Reset mid-burst: ownership and the read pipeline are cleared immediately, and a pending RVALID is dropped.
- Simultaneous REQ in OWN_x: the non-owner waits with no timeout. A locked owner can starve the other port by design.
- Back-to-back reads to alternating ports: the RVALID pulses follow issue order, one per cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin between the ports.
  - A 1-bit last-granted pointer updates on every grant made from IDLE.
  - On contention in IDLE, the port not granted last wins.
- SRAM_ARB_RR_EN undefined: fixed priority, control loader always wins contention in IDLE. No pointer flop exists.

## Test plan
- Single CPU read, SRAM preloaded 0xA5 at 0x1F0: P_GNT in cycle 0; CEN=0, A=0x1F0 after edge 0; P_RVALID=1 with P_RDATA=0xA5 after edge 1; C_RVALID stays 0.
- Control write 0x3C to 0x000 followed by a CPU read of 0x000: WEN=0 then WEN=1 on consecutive cycles; P_RDATA=0x3C.
- Contention, both REQ high in IDLE for 4 cycles, no LOCK:
  - Fixed priority: C granted all 4 cycles.
  - With SRAM_ARB_RR_EN: grants alternate C, P, C, P.
- Burst lock: C_LOCK=1 with 3 C writes; P_REQ high throughout:
  - P_GNT=0 until C_LOCK drops.
  - P is granted in the cycle C_LOCK=0.
  - The idle locked cycle shows CEN=1.
- Reset asserted the cycle after a read is accepted: RVALID never pulses; all outputs return to reset values asynchronously; the first grant after release is normal.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM between the control loader (C) and the CPU (P),
// with registered SRAM pins and owner-tagged read return. SRAM_ARB_RR_EN selects round-robin contention.
module sram_port_arbiter #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         C_REQ,
    input  logic                         C_LOCK,
    input  logic                         C_WE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] C_ADDR,
    input  logic [MEMORY_DATA_WIDTH-1:0] C_WDATA,
    output logic                         C_GNT,
    output logic                         C_RVALID,
    output logic [MEMORY_DATA_WIDTH-1:0] C_RDATA,
    input  logic                         P_REQ,
    input  logic                         P_LOCK,
    input  logic                         P_WE,
    input  logic [MEMORY_ADDR_WIDTH-1:0] P_ADDR,
    input  logic [MEMORY_DATA_WIDTH-1:0] P_WDATA,
    output logic                         P_GNT,
    output logic                         P_RVALID,
    output logic [MEMORY_DATA_WIDTH-1:0] P_RDATA,
    output logic                         CEN_after_mux,
    output logic                         WEN_after_mux,
    output logic [MEMORY_ADDR_WIDTH-1:0] A_after_mux,
    output logic [MEMORY_DATA_WIDTH-1:0] D_after_mux,
    input  logic [MEMORY_DATA_WIDTH-1:0] Q_from_SRAM
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_P = 2'd2
    } state_t;

    state_t     state;
    logic       arb_free;
    logic       c_prio;
    logic       c_win;
    logic       p_win;
    logic [1:0] rd_s1;   // [1] = P read, [0] = C read
    logic [1:0] rd_s2;

`ifdef SRAM_ARB_RR_EN
    logic rr_p_next;     // 1: P wins the next contention in IDLE

    assign c_prio = ~rr_p_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_p_next <= 1'b0;
        end else if (arb_free && (c_win || p_win)) begin
            rr_p_next <= c_win;
        end
    end
`else
    assign c_prio = 1'b1;
`endif

    // Handshake: xREQ acts as valid and xGNT as ready; an access is accepted on the
    // rising edge where both are high, and request fields must be stable until then.
    always_comb begin
        arb_free = !((state == OWN_C && C_LOCK) || (state == OWN_P && P_LOCK));
        c_win    = 1'b0;
        p_win    = 1'b0;
        if (arb_free) begin
            c_win = C_REQ && (!P_REQ || c_prio);
            p_win = P_REQ && !c_win;
        end else if (state == OWN_C) begin
            c_win = C_REQ;
        end else begin
            p_win = P_REQ;
        end
        if (!RST_N) begin
            c_win = 1'b0;
            p_win = 1'b0;
        end
    end

    assign C_GNT = c_win;
    assign P_GNT = p_win;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            CEN_after_mux <= 1'b1;
            WEN_after_mux <= 1'b1;
            A_after_mux   <= '0;
            D_after_mux   <= '0;
            rd_s1         <= 2'b00;
            rd_s2         <= 2'b00;
        end else begin
            rd_s1 <= {p_win && !P_WE, c_win && !C_WE};
            rd_s2 <= rd_s1;
            if (c_win) begin
                CEN_after_mux <= 1'b0;
                WEN_after_mux <= ~C_WE;
                A_after_mux   <= C_ADDR;
                D_after_mux   <= C_WDATA;
                state         <= C_LOCK ? OWN_C : IDLE;
            end else if (p_win) begin
                CEN_after_mux <= 1'b0;
                WEN_after_mux <= ~P_WE;
                A_after_mux   <= P_ADDR;
                D_after_mux   <= P_WDATA;
                state         <= P_LOCK ? OWN_P : IDLE;
            end else begin
                CEN_after_mux <= 1'b1;
                WEN_after_mux <= 1'b1;
                if (arb_free) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Tag reaches rd_s2 the cycle the SRAM presents Q for that read.
    assign C_RVALID = rd_s2[0];
    assign P_RVALID = rd_s2[1];
    assign C_RDATA  = rd_s2[0] ? Q_from_SRAM : '0;
    assign P_RDATA  = rd_s2[1] ? Q_from_SRAM : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 512x8 synchronous SRAM.
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_req = 1'b0, c_lock = 1'b0, c_we = 1'b0;
    logic [8:0] c_addr = '0;
    logic [7:0] c_wdata = '0;
    logic       c_gnt, c_rvalid;
    logic [7:0] c_rdata;
    logic       p_req = 1'b0, p_lock = 1'b0, p_we = 1'b0;
    logic [8:0] p_addr = '0;
    logic [7:0] p_wdata = '0;
    logic       p_gnt, p_rvalid;
    logic [7:0] p_rdata;
    logic       cen, wen;
    logic [8:0] a;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] mem [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9)) dut (
        .CLK(clk), .RST_N(rst_n),
        .C_REQ(c_req), .C_LOCK(c_lock), .C_WE(c_we), .C_ADDR(c_addr), .C_WDATA(c_wdata),
        .C_GNT(c_gnt), .C_RVALID(c_rvalid), .C_RDATA(c_rdata),
        .P_REQ(p_req), .P_LOCK(p_lock), .P_WE(p_we), .P_ADDR(p_addr), .P_WDATA(p_wdata),
        .P_GNT(p_gnt), .P_RVALID(p_rvalid), .P_RDATA(p_rdata),
        .CEN_after_mux(cen), .WEN_after_mux(wen), .A_after_mux(a), .D_after_mux(d),
        .Q_from_SRAM(q)
    );

    // SRAM model; the 0x1F0 preload is applied while reset is held
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[9'h1F0] <= 8'hA5;
        end else if (!cen) begin
            if (!wen) mem[a] <= d;
            else      q <= mem[a];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        c_req = 1'b1; p_req = 1'b1;
        step(); step();
        #1;
        if (cen !== 1'b1) begin $display("FAIL reset_cen got %b exp 1", cen); errors++; end checks++;
        if (wen !== 1'b1) begin $display("FAIL reset_wen got %b exp 1", wen); errors++; end checks++;
        if (a !== 9'h000) begin $display("FAIL reset_a got %h exp 000", a); errors++; end checks++;
        if (d !== 8'h00) begin $display("FAIL reset_d got %h exp 00", d); errors++; end checks++;
        if (c_gnt !== 1'b0) begin $display("FAIL reset_c_gnt got %b exp 0", c_gnt); errors++; end checks++;
        if (p_gnt !== 1'b0) begin $display("FAIL reset_p_gnt got %b exp 0", p_gnt); errors++; end checks++;
        if (c_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin $display("FAIL reset_rvalid got %b%b exp 00", c_rvalid, p_rvalid); errors++; end checks++;
        if (c_rdata !== 8'h00 || p_rdata !== 8'h00) begin $display("FAIL reset_rdata got %h %h exp 00 00", c_rdata, p_rdata); errors++; end checks++;
        c_req = 1'b0; p_req = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h1F0;
        #1;
        if (p_gnt !== 1'b1) begin $display("FAIL sr_p_gnt got %b exp 1", p_gnt); errors++; end checks++;
        if (c_gnt !== 1'b0) begin $display("FAIL sr_c_gnt got %b exp 0", c_gnt); errors++; end checks++;
        step();
        if (cen !== 1'b0 || wen !== 1'b1) begin $display("FAIL sr_pins got cen %b wen %b exp 0 1", cen, wen); errors++; end checks++;
        if (a !== 9'h1F0) begin $display("FAIL sr_a got %h exp 1f0", a); errors++; end checks++;
        if (p_rvalid !== 1'b0) begin $display("FAIL sr_early_rvalid got %b exp 0", p_rvalid); errors++; end checks++;
        p_req = 1'b0;
        step();
        if (p_rvalid !== 1'b1) begin $display("FAIL sr_p_rvalid got %b exp 1", p_rvalid); errors++; end checks++;
        if (p_rdata !== 8'hA5) begin $display("FAIL sr_p_rdata got %h exp a5", p_rdata); errors++; end checks++;
        if (c_rvalid !== 1'b0) begin $display("FAIL sr_c_rvalid got %b exp 0", c_rvalid); errors++; end checks++;
        if (cen !== 1'b1) begin $display("FAIL sr_idle_cen got %b exp 1", cen); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b0) begin $display("FAIL sr_pulse_width got %b exp 0", p_rvalid); errors++; end checks++;
    endtask

    task automatic test_write_read();
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h000; c_wdata = 8'h3C;
        #1;
        if (c_gnt !== 1'b1) begin $display("FAIL wr_c_gnt got %b exp 1", c_gnt); errors++; end checks++;
        step();
        if (cen !== 1'b0 || wen !== 1'b0) begin $display("FAIL wr_pins got cen %b wen %b exp 0 0", cen, wen); errors++; end checks++;
        if (d !== 8'h3C) begin $display("FAIL wr_d got %h exp 3c", d); errors++; end checks++;
        c_req = 1'b0; c_we = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h000;
        #1;
        if (p_gnt !== 1'b1) begin $display("FAIL wr_p_gnt got %b exp 1", p_gnt); errors++; end checks++;
        step();
        if (cen !== 1'b0 || wen !== 1'b1) begin $display("FAIL rd_pins got cen %b wen %b exp 0 1", cen, wen); errors++; end checks++;
        if (a !== 9'h000) begin $display("FAIL rd_a got %h exp 000", a); errors++; end checks++;
        if (c_rvalid !== 1'b0) begin $display("FAIL wr_no_rvalid got %b exp 0", c_rvalid); errors++; end checks++;
        p_req = 1'b0;
        step();
        if (p_rvalid !== 1'b1 || p_rdata !== 8'h3C) begin $display("FAIL wr_readback got %b %h exp 1 3c", p_rvalid, p_rdata); errors++; end checks++;
        if (c_rvalid !== 1'b0) begin $display("FAIL wr_c_rvalid got %b exp 0", c_rvalid); errors++; end checks++;
        step();
    endtask

    task automatic test_contention();
        logic [3:0] exp_c;
`ifdef SRAM_ARB_RR_EN
        exp_c = 4'b0101;
`else
        exp_c = 4'b1111;
`endif
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h1F0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h000;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (c_gnt !== exp_c[i]) begin $display("FAIL cont_c_gnt[%0d] got %b exp %b", i, c_gnt, exp_c[i]); errors++; end checks++;
            if (p_gnt !== !exp_c[i]) begin $display("FAIL cont_p_gnt[%0d] got %b exp %b", i, p_gnt, !exp_c[i]); errors++; end checks++;
            step();
        end
        c_req = 1'b0; p_req = 1'b0;
        step();
        if (c_rvalid !== exp_c[3]) begin $display("FAIL cont_last_c_rvalid got %b exp %b", c_rvalid, exp_c[3]); errors++; end checks++;
        step();
        if (c_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin $display("FAIL cont_flush got %b%b exp 00", c_rvalid, p_rvalid); errors++; end checks++;
    endtask

    task automatic test_back_to_back();
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h1F0;
        #1;
        if (c_gnt !== 1'b1) begin $display("FAIL b2b_c_gnt got %b exp 1", c_gnt); errors++; end checks++;
        step();
        c_req = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h000;
        #1;
        if (p_gnt !== 1'b1) begin $display("FAIL b2b_p_gnt got %b exp 1", p_gnt); errors++; end checks++;
        step();
        p_req = 1'b0;
        if (c_rvalid !== 1'b1 || c_rdata !== 8'hA5) begin $display("FAIL b2b_c_ret got %b %h exp 1 a5", c_rvalid, c_rdata); errors++; end checks++;
        if (p_rvalid !== 1'b0) begin $display("FAIL b2b_p_early got %b exp 0", p_rvalid); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b1 || p_rdata !== 8'h3C) begin $display("FAIL b2b_p_ret got %b %h exp 1 3c", p_rvalid, p_rdata); errors++; end checks++;
        if (c_rvalid !== 1'b0) begin $display("FAIL b2b_c_late got %b exp 0", c_rvalid); errors++; end checks++;
        step();
    endtask

    task automatic test_burst_lock();
        c_req = 1'b1; c_lock = 1'b1; c_we = 1'b1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h000;
        for (int i = 0; i < 3; i++) begin
            c_addr = 9'h010 + 9'(i); c_wdata = 8'h11 + 8'(i);
            #1;
            if (c_gnt !== 1'b1 || p_gnt !== 1'b0) begin $display("FAIL lock_gnt[%0d] got c%b p%b exp c1 p0", i, c_gnt, p_gnt); errors++; end checks++;
            step();
            if (cen !== 1'b0 || wen !== 1'b0 || a !== 9'h010 + 9'(i)) begin $display("FAIL lock_wr[%0d] got cen %b wen %b a %h", i, cen, wen, a); errors++; end checks++;
        end
        c_req = 1'b0; c_we = 1'b0;
        #1;
        if (c_gnt !== 1'b0 || p_gnt !== 1'b0) begin $display("FAIL lock_hold_gnt got c%b p%b exp c0 p0", c_gnt, p_gnt); errors++; end checks++;
        step();
        if (cen !== 1'b1 || wen !== 1'b1) begin $display("FAIL lock_hold_pins got cen %b wen %b exp 1 1", cen, wen); errors++; end checks++;
        c_lock = 1'b0;
        #1;
        if (p_gnt !== 1'b1 || c_gnt !== 1'b0) begin $display("FAIL lock_release_gnt got c%b p%b exp c0 p1", c_gnt, p_gnt); errors++; end checks++;
        step();
        p_req = 1'b0;
        if (cen !== 1'b0 || wen !== 1'b1 || a !== 9'h000) begin $display("FAIL lock_p_pins got cen %b wen %b a %h", cen, wen, a); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b1 || p_rdata !== 8'h3C) begin $display("FAIL lock_p_ret got %b %h exp 1 3c", p_rvalid, p_rdata); errors++; end checks++;
        step();
    endtask

    task automatic test_reset_mid();
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h1F0;
        #1;
        if (p_gnt !== 1'b1) begin $display("FAIL rm_gnt got %b exp 1", p_gnt); errors++; end checks++;
        step();
        if (cen !== 1'b0) begin $display("FAIL rm_accept_cen got %b exp 0", cen); errors++; end checks++;
        rst_n = 1'b0;
        #1;
        if (cen !== 1'b1 || wen !== 1'b1) begin $display("FAIL rm_async_pins got cen %b wen %b exp 1 1", cen, wen); errors++; end checks++;
        if (a !== 9'h000 || d !== 8'h00) begin $display("FAIL rm_async_ad got a %h d %h exp 000 00", a, d); errors++; end checks++;
        if (p_gnt !== 1'b0) begin $display("FAIL rm_gnt_forced got %b exp 0", p_gnt); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b0 || p_rdata !== 8'h00) begin $display("FAIL rm_rvalid_drop got %b %h exp 0 00", p_rvalid, p_rdata); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b0) begin $display("FAIL rm_rvalid_late got %b exp 0", p_rvalid); errors++; end checks++;
        rst_n = 1'b1;
        #1;
        if (p_gnt !== 1'b1) begin $display("FAIL rm_post_gnt got %b exp 1", p_gnt); errors++; end checks++;
        step();
        p_req = 1'b0;
        if (cen !== 1'b0 || a !== 9'h1F0) begin $display("FAIL rm_post_pins got cen %b a %h exp 0 1f0", cen, a); errors++; end checks++;
        step();
        if (p_rvalid !== 1'b1 || p_rdata !== 8'hA5) begin $display("FAIL rm_post_ret got %b %h exp 1 a5", p_rvalid, p_rdata); errors++; end checks++;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_burst_lock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
